// File: rtl/rd_ptr_fwft_ctrl.sv
// Read-side controller of an asynchronous FIFO.
// Brings the Gray write pointer into the read clock domain and detects when the RAM is empty.
// Drives the RAM read address and presents data first-word-fall-through on a valid/ready port.
// Exports binary and Gray read pointers, the RAM occupancy and an almost-empty flag.
module rd_ptr_fwft_ctrl #(
   parameter int W         = 3,
   parameter int DATA_W    = 8,
   parameter int AE_THRESH = 1
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic [W:0]        g_wr_ptr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              dout_ready,
   output logic [W-1:0]      rd_addr,
   output logic [W:0]        b_rd_ptr,
   output logic [W:0]        g_rd_ptr,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              empty,
   output logic [W:0]        rd_level,
   output logic              almost_empty
);

   localparam logic [W:0] AE_LIMIT = AE_THRESH[W:0];
   localparam logic [W:0] PTR_ONE  = {{W{1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Write pointer synchronizer stages (Gray coded, so at most one bit moves per write)
   logic [W:0] g_wr_s1_q;
   logic [W:0] g_wr_sync_q;
   logic [W:0] b_wr_sync;

   // Read pointer, output register and status
   state_t            state_q, state_d;
   logic [W:0]        b_rd_ptr_q, b_rd_ptr_d;
   logic [W:0]        g_rd_ptr_q, g_rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [W:0]        rd_level_q, rd_level_d;
   logic              almost_empty_q, almost_empty_d;
   logic              mem_empty;
   logic              fetch;

   // Two-flop synchronizer for the Gray write pointer
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         g_wr_s1_q   <= '0;
         g_wr_sync_q <= '0;
      end else begin
         g_wr_s1_q   <= g_wr_ptr;
         g_wr_sync_q <= g_wr_s1_q;
      end
   end

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
   assign b_wr_sync[W] = g_wr_sync_q[W];
   generate
      for (genvar gi = W - 1; gi >= 0; gi--) begin : g_gray2bin
         assign b_wr_sync[gi] = b_wr_sync[gi+1] ^ g_wr_sync_q[gi];
      end
   endgenerate

   // Equal Gray pointers (including the lap bit) means nothing is left in RAM
   assign mem_empty = (g_rd_ptr_q == g_wr_sync_q);

   // Output FSM: decides when to pull the next word out of RAM into the output register
   always_comb begin
      state_d        = state_q;
      fetch          = 1'b0;
      dout_d         = dout_q;
      b_rd_ptr_d     = b_rd_ptr_q;
      g_rd_ptr_d     = g_rd_ptr_q;
      rd_level_d     = b_wr_sync - b_rd_ptr_q;
      almost_empty_d = (rd_level_d <= AE_LIMIT);

      case (state_q)
         IDLE: begin
            // dout_ready is irrelevant here: nothing is being offered
            if (!mem_empty) begin
               fetch   = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (dout_ready) begin
               if (!mem_empty) begin
                  fetch   = 1'b1;
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (fetch) begin
         dout_d     = mem_rdata;
         b_rd_ptr_d = b_rd_ptr_q + PTR_ONE;
         g_rd_ptr_d = (b_rd_ptr_d >> 1) ^ b_rd_ptr_d;
      end
   end

   // State, pointers, output word and occupancy registers
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q        <= IDLE;
         b_rd_ptr_q     <= '0;
         g_rd_ptr_q     <= '0;
         dout_q         <= '0;
         rd_level_q     <= '0;
         almost_empty_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         b_rd_ptr_q     <= b_rd_ptr_d;
         g_rd_ptr_q     <= g_rd_ptr_d;
         dout_q         <= dout_d;
         rd_level_q     <= rd_level_d;
         almost_empty_q <= almost_empty_d;
      end
   end

   assign rd_addr      = b_rd_ptr_q[W-1:0];
   assign b_rd_ptr     = b_rd_ptr_q;
   assign g_rd_ptr     = g_rd_ptr_q;
   assign dout         = dout_q;
   assign dout_valid   = (state_q == HOLD);
   assign empty        = (state_q != HOLD);
   assign rd_level     = rd_level_q;
   assign almost_empty = almost_empty_q;

endmodule
